// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF        = 25;
    localparam int unsigned DEFAULT_HALF_DEF = 12_499_999;  // 2 Hz at 50 MHz

    // Ceiling log2, minimum result 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Channel index width; the bank never exceeds eight channels.
    localparam int unsigned CH_IDX_W = clog2(8);

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active/pending half-period,
// square-wave output and a registered rising-edge tick.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ha_q, ha_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             pv_q, pv_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] half_next;
    logic             terminal;

    // Half-period to adopt at a terminal count or sync: a coincident write
    // wins over any older pending value.
    assign half_next = wr ? wr_half : (pv_q ? hp_q : ha_q);
    // >= rather than == so a disabled-channel load that lowers H below the
    // held count ends the half-period instead of wrapping the counter.
    assign terminal  = (cnt_q >= ha_q);

    // Next-state logic; priority sync > load > count.
    always_comb begin
        cnt_d  = cnt_q;
        ha_d   = ha_q;
        hp_d   = hp_q;
        pv_d   = pv_q;
        out_d  = out_q;
        tick_d = 1'b0;
        if (sync) begin
            cnt_d = '0;
            out_d = 1'b0;
            ha_d  = half_next;
            pv_d  = 1'b0;
        end else if (en) begin
            if (terminal) begin
                cnt_d  = '0;
                out_d  = ~out_q;
                tick_d = ~out_q;
                ha_d   = half_next;
                pv_d   = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wr) begin
                    hp_d = wr_half;
                    pv_d = 1'b1;
                end
            end
        end else if (wr) begin
            // Idle channel: no half-period in flight, take the value now.
            ha_d = wr_half;
            pv_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ha_q   <= CNT_W'(DEFAULT_HALF);
            hp_q   <= CNT_W'(DEFAULT_HALF);
            pv_q   <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ha_q   <= ha_d;
            hp_q   <= hp_d;
            pv_q   <= pv_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers. Outputs are enables /
// levels for logic in the clk_50MHz domain, not clocks.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic                clk_50MHz,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     en,
    input  logic                sync,
    input  logic                load,
    input  logic [CH_IDX_W-1:0] load_ch,
    input  logic [CNT_W-1:0]    load_half,
    output logic [N_CH-1:0]     clk_out,
    output logic [N_CH-1:0]     tick
);

    logic [N_CH-1:0] wr;

    // Decode load_ch into per-channel write strobes; indices >= N_CH match none.
    always_comb begin
        wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr[i] = load && (load_ch == CH_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk     (clk_50MHz),
            .rst_n   (rst_n),
            .en      (en[g]),
            .sync    (sync),
            .wr      (wr[g]),
            .wr_half (load_half),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed table, corner sequences and
// random stimulus against a remaining-cycles reference model.
module tb_clk_div_bank;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int DEF = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] en = '0;
    logic         sync = 1'b0;
    logic         load = 1'b0;
    logic [2:0]   load_ch = '0;
    logic [W-1:0] load_half = '0;
    logic [N-1:0] clk_out;
    logic [N-1:0] tick;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles remaining until the next toggle, per channel.
    int m_rem [N];
    int m_ha  [N];
    int m_hp  [N];
    bit m_pv  [N];
    bit m_lvl [N];
    bit m_tick[N];

    clk_div_bank #(
        .N_CH         (N),
        .CNT_W        (W),
        .DEFAULT_HALF (DEF)
    ) dut (
        .clk_50MHz (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .load      (load),
        .load_ch   (load_ch),
        .load_half (load_half),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] exp_clk;
        logic [N-1:0] exp_tick;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit w;
            w = load && (int'(load_ch) == c);
            if (!rst_n) begin
                m_ha[c] = DEF; m_hp[c] = DEF; m_pv[c] = 0;
                m_lvl[c] = 0; m_tick[c] = 0; m_rem[c] = DEF + 1;
            end else if (sync) begin
                m_ha[c] = w ? int'(load_half) : (m_pv[c] ? m_hp[c] : m_ha[c]);
                m_pv[c] = 0; m_lvl[c] = 0; m_tick[c] = 0; m_rem[c] = m_ha[c] + 1;
            end else if (en[c]) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_tick[c] = m_lvl[c];
                    if (w) m_ha[c] = int'(load_half);
                    else if (m_pv[c]) m_ha[c] = m_hp[c];
                    m_pv[c] = 0;
                    m_rem[c] = m_ha[c] + 1;
                end else begin
                    m_tick[c] = 0;
                    if (w) begin
                        m_hp[c] = int'(load_half);
                        m_pv[c] = 1;
                    end
                end
            end else begin
                m_tick[c] = 0;
                if (w) begin
                    int elapsed;
                    elapsed = m_ha[c] + 1 - m_rem[c];
                    m_ha[c] = int'(load_half);
                    m_pv[c] = 0;
                    m_rem[c] = (m_ha[c] + 1 > elapsed) ? m_ha[c] + 1 - elapsed : 1;
                end
            end
        end
    endtask

    // One clock: step the model at the edge, compare #1 later.
    task automatic cycle();
        logic [N-1:0] ec, et;
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < N; c++) begin
            ec[c] = m_lvl[c];
            et[c] = m_tick[c];
        end
        check("clk_out vs model", 32'(clk_out), 32'(ec));
        check("tick vs model", 32'(tick), 32'(et));
    endtask

    task automatic do_load(input int ch, input int h);
        load = 1'b1; load_ch = 3'(ch); load_half = W'(h);
        cycle();
        load = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        int k;
        logic prev;

        // After reset with H=3: rise on the 4th edge, period 8, all in phase.
        tbl[0]  = '{4'hF, 4'h0, 4'h0};
        tbl[1]  = '{4'hF, 4'h0, 4'h0};
        tbl[2]  = '{4'hF, 4'h0, 4'h0};
        tbl[3]  = '{4'hF, 4'hF, 4'hF};
        tbl[4]  = '{4'hF, 4'hF, 4'h0};
        tbl[5]  = '{4'hF, 4'hF, 4'h0};
        tbl[6]  = '{4'hF, 4'hF, 4'h0};
        tbl[7]  = '{4'hF, 4'h0, 4'h0};
        tbl[8]  = '{4'hF, 4'h0, 4'h0};
        tbl[9]  = '{4'hF, 4'h0, 4'h0};
        tbl[10] = '{4'hF, 4'h0, 4'h0};
        tbl[11] = '{4'hF, 4'hF, 4'hF};

        for (int c = 0; c < N; c++) begin
            m_rem[c] = 0; m_ha[c] = 0; m_hp[c] = 0;
            m_pv[c] = 0; m_lvl[c] = 0; m_tick[c] = 0;
        end

        #1;
        rst_n = 1'b0;
        en = 4'hF;
        cycle();
        cycle();
        check("reset clk_out", 32'(clk_out), 32'h0);
        check("reset tick", 32'(tick), 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            en = tbl[i].en;
            cycle();
            check("table clk_out", 32'(clk_out), 32'(tbl[i].exp_clk));
            check("table tick", 32'(tick), 32'(tbl[i].exp_tick));
        end

        // Mid half-period load on ch1.
        cycle();
        do_load(1, 1);
        for (int i = 0; i < 16; i++) cycle();

        // Hold ch2 for 5 cycles.
        en = 4'b1011;
        for (int i = 0; i < 5; i++) cycle();
        en = 4'hF;
        for (int i = 0; i < 16; i++) cycle();

        // ch3 -> H=0, then sync everything.
        do_load(3, 0);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync clears clk_out", 32'(clk_out), 32'h0);
        for (int i = 0; i < 12; i++) cycle();

        // Load coinciding with ch0 terminal count: next half is 6 cycles.
        k = 0;
        while (m_rem[0] != 1 && k < 20) begin
            cycle();
            k++;
        end
        check("ch0 terminal reached", 32'(m_rem[0]), 32'd1);
        do_load(0, 5);
        prev = clk_out[0];
        k = 1;
        while (k <= 20) begin
            cycle();
            if (clk_out[0] != prev) break;
            k++;
        end
        check("coincident half length", 32'(k), 32'd6);

        // Out-of-range channel index is ignored.
        do_load(5, 1);
        for (int i = 0; i < 14; i++) cycle();

        // Reset with a pending load on ch1 discards it.
        cycle();
        do_load(1, 4);
        rst_n = 1'b0;
        cycle();
        check("mid reset clk_out", 32'(clk_out), 32'h0);
        check("mid reset tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("post reset pre-rise", 32'(clk_out), 32'h0);
        cycle();
        check("post reset rise", 32'(clk_out), 32'hF);
        for (int i = 0; i < 12; i++) cycle();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
            sync      = ($urandom_range(0, 49) == 0);
            load      = ($urandom_range(0, 5) == 0);
            load_ch   = 3'($urandom_range(0, 7));
            load_half = W'($urandom_range(0, 5));
            cycle();
        end
        rst_n = 1'b1; sync = 1'b0; load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
